// File: rtl/fp_pipe_pkg.sv
// Shared constants, state encoding and payload sizing for the FP adder pipeline stages.
// Payload layout is {rm, is_nan, is_inf, inf_nan_frac, sign, exp, frac}.
package fp_pipe_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP64_EXP_W  = 11;
  localparam int FP64_FRAC_W = 52;

  // guard, round, sticky below the stored fraction
  localparam int GRS_BITS = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // overflow + hidden + stored fraction + GRS
  function automatic int calc_frac_w(input int frac_w);
    return frac_w + GRS_BITS + 2;
  endfunction

  function automatic int payload_w(input int exp_w, input int frac_w);
    return 2 + 1 + 1 + frac_w + 1 + exp_w + calc_frac_w(frac_w);
  endfunction

endpackage

// File: rtl/fadd_cal_norm_skid.sv
// Calc->normalize register slice: two-entry skid buffer, 1-cycle latency, full throughput.
// Backpressure: in_ready is registered state only; a full buffer stalls upstream, flush empties it.
module fadd_cal_norm_skid
  import fp_pipe_pkg::*;
#(
  parameter int EXP_W  = FP32_EXP_W,
  parameter int FRAC_W = FP32_FRAC_W,
  parameter int CNT_W  = 16,
  localparam int WF    = FRAC_W + GRS_BITS + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rm,
  input  logic              in_is_nan,
  input  logic              in_is_inf,
  input  logic [FRAC_W-1:0] in_inf_nan_frac,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [WF-1:0]     in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_rm,
  output logic              out_is_nan,
  output logic              out_is_inf,
  output logic [FRAC_W-1:0] out_inf_nan_frac,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [WF-1:0]     out_frac,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = payload_w(EXP_W, FRAC_W);

  skid_state_e      state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [PW-1:0]    in_pay;
  logic             in_fire;
  logic             out_fire;

  assign in_pay = {in_rm, in_is_nan, in_is_inf, in_inf_nan_frac,
                   in_sign, in_exp, in_frac};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // flush wins over any transfer; a same-cycle out_fire is still delivered
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_pay;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_pay;
          end else if (in_fire) begin
            skid_d  = in_pay;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY) && !rst;
    in_ready  = (state_q != ST_FULL) && !rst;
    occ       = 2'd0;
    if (!rst) begin
      case (state_q)
        ST_ONE:  occ = 2'd1;
        ST_FULL: occ = 2'd2;
        default: occ = 2'd0;
      endcase
    end
    {out_rm, out_is_nan, out_is_inf, out_inf_nan_frac,
     out_sign, out_exp, out_frac} = rst ? {PW{1'b0}} : main_q;
    stall_cnt = stall_q;
  end

endmodule
